// File: rtl/ram_block_loader.sv
// ram_block_loader: reads NUM blocks of BLK_W bits from a synchronous RAM
// and hands each one to the AES core over a valid/ready handshake.
module ram_block_loader #(
  parameter int RAM_DW    = 8,
  parameter int RAM_AW    = 8,
  parameter int BLK_W     = 128,
  parameter int NB_W      = 4,
  parameter int RD_LAT    = 1,
  parameter int START_DLY = 16,
  parameter int MSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [RAM_AW-1:0] base_addr,
  input  logic [NB_W-1:0]   num_blk,
  output logic              ram_en,
  output logic [RAM_AW-1:0] ram_addr,
  input  logic [RAM_DW-1:0] ram_data,
  output logic [BLK_W-1:0]  blk_data,
  output logic              blk_valid,
  input  logic              blk_ready,
  output logic              busy,
  output logic              done
);

  localparam int WPB = BLK_W / RAM_DW;
  localparam int CW  = $clog2(WPB + 1);
  localparam int DW  = (START_DLY > 1) ? $clog2(START_DLY + 1) : 1;

  localparam logic [DW-1:0] DLY_LAST =
    DW'((START_DLY > 0) ? START_DLY - 1 : 0);
  localparam logic [CW-1:0] W_LAST = CW'(WPB - 1);

  typedef enum logic [2:0] {
    IDLE, DLY, FETCH, DRAIN, HOLD, FIN
  } state_t;

  state_t state, nxt;

  logic [RAM_AW-1:0] addr;
  logic [NB_W-1:0]   left;
  logic [DW-1:0]     dcnt;
  logic [CW-1:0]     icnt;
  logic [CW-1:0]     ccnt;
  logic [RD_LAT-1:0] pipe;
  logic              cap;
  logic [CW-1:0]     slot;

  assign cap  = pipe[RD_LAT-1];
  assign slot = (MSB_FIRST != 0) ? (W_LAST - ccnt) : ccnt;

  assign ram_en    = (state == FETCH);
  assign ram_addr  = addr;
  assign blk_valid = (state == HOLD);
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // next-state decode
  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (num_blk == '0)        nxt = FIN;
          else if (START_DLY == 0)  nxt = FETCH;
          else                      nxt = DLY;
        end
      end
      DLY:   if (dcnt == DLY_LAST) nxt = FETCH;
      FETCH: if (icnt == W_LAST)   nxt = DRAIN;
      DRAIN: if (cap && ccnt == W_LAST) nxt = HOLD;
      HOLD: begin
        if (blk_ready) begin
          if (left == NB_W'(1)) nxt = FIN;
          else                  nxt = FETCH;
        end
      end
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // read-enable pipeline marking returning RAM words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe <= '0;
    end else begin
      pipe[0] <= ram_en;
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  // address, block and delay counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
      left <= '0;
      dcnt <= '0;
      icnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addr <= base_addr;
            left <= num_blk;
            dcnt <= '0;
            icnt <= '0;
          end
        end
        DLY: dcnt <= dcnt + 1'b1;
        FETCH: begin
          addr <= addr + 1'b1;
          icnt <= icnt + 1'b1;
        end
        HOLD: begin
          if (blk_ready) begin
            left <= left - 1'b1;
            icnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // capture returning words into their block slice
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_data <= '0;
      ccnt     <= '0;
    end else if (state == IDLE && start) begin
      ccnt <= '0;
    end else if (state == HOLD && blk_ready) begin
      ccnt <= '0;
    end else if (cap) begin
      blk_data[int'(slot)*RAM_DW +: RAM_DW] <= ram_data;
      ccnt <= ccnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ram_block_loader.sv
// tb_ram_block_loader: scoreboard bench for ram_block_loader, one default
// instance and one MSB_FIRST/RD_LAT=2 instance on identity RAMs.
module tb_ram_block_loader;

  logic         clk = 0;
  logic         rst_n = 0;

  logic         start0 = 0, start1 = 0;
  logic [7:0]   base0 = 0, base1 = 0;
  logic [3:0]   nb0 = 0, nb1 = 0;
  logic         ram_en0, ram_en1;
  logic [7:0]   ram_addr0, ram_addr1;
  logic [7:0]   ram_data0 = 0, r1a = 0, r1b = 0;
  logic [127:0] blk_data0, blk_data1;
  logic         blk_valid0, blk_valid1;
  logic         ready0 = 1, ready1 = 1;
  logic         busy0, busy1, done0, done1;

  int total = 0;
  int bad = 0;

  logic [127:0] q0[$];
  logic [127:0] q1[$];

  int cyc = 0;
  int en_cnt0 = 0, val_cnt0 = 0, done_cnt0 = 0;
  int last_en0 = 0, last_en1 = 0;
  logic pv0 = 0, pr0 = 0, pv1 = 0;
  logic [127:0] pd0 = 0;

  always #5 clk = ~clk;

  ram_block_loader u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .base_addr(base0),
    .num_blk(nb0), .ram_en(ram_en0), .ram_addr(ram_addr0),
    .ram_data(ram_data0), .blk_data(blk_data0), .blk_valid(blk_valid0),
    .blk_ready(ready0), .busy(busy0), .done(done0)
  );

  ram_block_loader #(.RD_LAT(2), .MSB_FIRST(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .base_addr(base1),
    .num_blk(nb1), .ram_en(ram_en1), .ram_addr(ram_addr1),
    .ram_data(r1b), .blk_data(blk_data1), .blk_valid(blk_valid1),
    .blk_ready(ready1), .busy(busy1), .done(done1)
  );

  // identity RAMs: RAM[a] = a, latency 1 and 2
  always @(posedge clk) begin
    if (ram_en0) ram_data0 <= ram_addr0;
    if (ram_en1) r1a <= ram_addr1;
    r1b <= r1a;
  end

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] exp_blk(input logic [7:0] base,
                                           input int k, input bit msb);
    logic [127:0] b = '0;
    for (int w = 0; w < 16; w++) begin
      int s = msb ? 15 - w : w;
      b[s*8 +: 8] = base + 8'(16*k + w);
    end
    return b;
  endfunction

  // monitor for the default instance
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      pv0 <= 0; pr0 <= 0; pv1 <= 0;
    end else begin
      if (ram_en0) begin en_cnt0++; last_en0 = cyc; end
      if (ram_en1) last_en1 = cyc;
      if (done0) done_cnt0++;
      if (blk_valid0) begin
        val_cnt0++;
        chk("hold_noen", ram_en0, 0);
        if (!pv0) chk("gap0", cyc - last_en0, 2);
        if (pv0 && !pr0) chk("hold_data", blk_data0, pd0);
        if (ready0) begin
          chk("sb0_nonempty", q0.size() > 0, 1);
          if (q0.size() > 0) chk("blk0", blk_data0, q0.pop_front());
        end
      end
      if (blk_valid1) begin
        if (!pv1) chk("gap1", cyc - last_en1, 3);
        if (ready1) begin
          chk("sb1_nonempty", q1.size() > 0, 1);
          if (q1.size() > 0) chk("blk1", blk_data1, q1.pop_front());
        end
      end
      pv0 <= blk_valid0;
      pr0 <= ready0;
      pd0 <= blk_data0;
      pv1 <= blk_valid1;
    end
  end

  task automatic pulse0(input logic [7:0] b, input logic [3:0] n);
    @(negedge clk);
    start0 = 1; base0 = b; nb0 = n;
    @(negedge clk);
    start0 = 0;
  endtask

  task automatic wait_idle0(input int lim);
    int n = 0;
    while (busy0 && n < lim) begin @(negedge clk); n++; end
    chk("idle0", busy0, 0);
    @(negedge clk);
  endtask

  initial begin
    int e, v, d, lat, n;

    repeat (3) @(negedge clk);
    chk("rst_en", ram_en0, 0);
    chk("rst_addr", ram_addr0, 0);
    chk("rst_data", blk_data0, 0);
    chk("rst_valid", blk_valid0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    rst_n = 1;
    repeat (2) @(negedge clk);

    // single block, LSB first, ready high
    e = en_cnt0; v = val_cnt0; d = done_cnt0;
    q0.push_back(128'h11100F0E0D0C0B0A0908070605040302);
    pulse0(8'h02, 4'd1);
    lat = 1;
    while (!ram_en0 && lat < 100) begin @(negedge clk); lat++; end
    chk("first_en_lat", lat, 17);
    wait_idle0(200);
    chk("s1_en", en_cnt0 - e, 16);
    chk("s1_valid", val_cnt0 - v, 1);
    chk("s1_done", done_cnt0 - d, 1);

    // back-pressure: ready low for 10 valid cycles
    e = en_cnt0; v = val_cnt0; d = done_cnt0;
    ready0 = 0;
    q0.push_back(128'h11100F0E0D0C0B0A0908070605040302);
    pulse0(8'h02, 4'd1);
    n = 0;
    while (!blk_valid0 && n < 200) begin @(negedge clk); n++; end
    chk("s2_valid_seen", blk_valid0, 1);
    repeat (10) @(negedge clk);
    ready0 = 1;
    wait_idle0(200);
    chk("s2_valid", val_cnt0 - v, 11);
    chk("s2_en", en_cnt0 - e, 16);
    chk("s2_done", done_cnt0 - d, 1);

    // two blocks wrapping the address space
    e = en_cnt0; v = val_cnt0; d = done_cnt0;
    q0.push_back(exp_blk(8'hF8, 0, 0));
    q0.push_back(exp_blk(8'hF8, 1, 0));
    pulse0(8'hF8, 4'd2);
    wait_idle0(300);
    chk("s3_en", en_cnt0 - e, 32);
    chk("s3_valid", val_cnt0 - v, 2);
    chk("s3_done", done_cnt0 - d, 1);

    // zero blocks, plus a start while busy that must be ignored
    e = en_cnt0; v = val_cnt0; d = done_cnt0;
    pulse0(8'h10, 4'd0);
    chk("s4_busy", busy0, 1);
    start0 = 1; nb0 = 4'd3;
    @(negedge clk);
    start0 = 0;
    repeat (40) @(negedge clk);
    chk("s4_en", en_cnt0 - e, 0);
    chk("s4_valid", val_cnt0 - v, 0);
    chk("s4_done", done_cnt0 - d, 1);
    chk("s4_idle", busy0, 0);

    // MSB-first, two-cycle RAM latency instance
    q1.push_back(128'h02030405060708090A0B0C0D0E0F1011);
    @(negedge clk);
    start1 = 1; base1 = 8'h02; nb1 = 4'd1;
    @(negedge clk);
    start1 = 0;
    n = 0;
    while (busy1 && n < 200) begin @(negedge clk); n++; end
    chk("s5_idle", busy1, 0);

    // reset during the 8th fetch cycle
    d = done_cnt0;
    q0.push_back(128'h11100F0E0D0C0B0A0908070605040302);
    pulse0(8'h02, 4'd1);
    n = 0; lat = 0;
    while (n < 8 && lat < 200) begin
      if (ram_en0) n++;
      if (n < 8) begin @(negedge clk); lat++; end
    end
    chk("s6_fetch8", n, 8);
    #2 rst_n = 0;
    #1;
    chk("s6_en", ram_en0, 0);
    chk("s6_addr", ram_addr0, 0);
    chk("s6_data", blk_data0, 0);
    chk("s6_valid", blk_valid0, 0);
    chk("s6_busy", busy0, 0);
    chk("s6_done", done0, 0);
    q0.delete();
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (30) @(negedge clk);
    chk("s6_nodone", done_cnt0 - d, 0);

    e = en_cnt0; v = val_cnt0; d = done_cnt0;
    q0.push_back(128'h11100F0E0D0C0B0A0908070605040302);
    pulse0(8'h02, 4'd1);
    lat = 1;
    while (!ram_en0 && lat < 100) begin @(negedge clk); lat++; end
    chk("s6_lat", lat, 17);
    wait_idle0(200);
    chk("s6_en_cnt", en_cnt0 - e, 16);
    chk("s6_valid_cnt", val_cnt0 - v, 1);
    chk("s6_done_cnt", done_cnt0 - d, 1);

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
